// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity modes,
// FSM state encodings, oversampling constants and a parity helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Parity bit over the low nbits of d; inverted for odd mode.
    function automatic logic parity_bit(
        input logic [8:0] d,
        input int         nbits,
        input int         mode
    );
        logic p;
        p = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < nbits) p ^= d[i];
        end
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, divide-by-BAUD_DIV tick
// prescaler and 16x-oversampled receive FSM with glitch rejection.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int BAUD_DIV  = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 idle
);

    localparam int PW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [1:0]           sync;
    logic                 rx_s;
    logic                 armed;
    logic [PW-1:0]        pcnt;
    logic                 tick;
    logic [3:0]           tcnt;
    logic [3:0]           idx;
    logic [DATA_BITS-1:0] shift;
    logic                 perr_pend;
    rx_state_t            state;

    assign rx_s = sync[1];
    assign tick = (pcnt == PW'(BAUD_DIV - 1));
    assign idle = (state == RX_IDLE);

    // Bring the asynchronous line into the clk domain, idling high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], rx_in};
    end

    // Receive FSM: edge detect, mid-bit sampling, completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RX_IDLE;
            armed         <= 1'b0;
            pcnt          <= '0;
            tcnt          <= '0;
            idx           <= '0;
            shift         <= '0;
            perr_pend     <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (rx_s) armed <= 1'b1;
            if (state == RX_IDLE) begin
                pcnt <= '0;
                tcnt <= '0;
                if (armed && !rx_s) state <= RX_START;
            end else begin
                pcnt <= tick ? '0 : pcnt + PW'(1);
                if (tick) begin
                    tcnt <= tcnt + 4'd1;
                    case (state)
                        RX_START: begin
                            if (tcnt == 4'(MID_SAMPLE - 1)) begin
                                tcnt <= '0;
                                idx  <= '0;
                                state <= rx_s ? RX_IDLE : RX_DATA;
                            end
                        end
                        RX_DATA: begin
                            if (tcnt == 4'(OVERSAMPLE - 1)) begin
                                shift <= {rx_s, shift[DATA_BITS-1:1]};
                                idx   <= idx + 4'd1;
                                if (idx == 4'(DATA_BITS - 1)) begin
                                    state <= (PARITY != PAR_NONE) ? RX_PARITY
                                                                  : RX_STOP;
                                end
                            end
                        end
                        RX_PARITY: begin
                            if (tcnt == 4'(OVERSAMPLE - 1)) begin
                                perr_pend <= rx_s != parity_bit(9'(shift),
                                                                DATA_BITS,
                                                                PARITY);
                                state <= RX_STOP;
                            end
                        end
                        RX_STOP: begin
                            if (tcnt == 4'(OVERSAMPLE - 1)) begin
                                state         <= RX_IDLE;
                                rx_valid      <= 1'b1;
                                rx_data       <= shift;
                                rx_frame_err  <= !rx_s;
                                rx_parity_err <= (PARITY != PAR_NONE)
                                                 && perr_pend;
                                if (!rx_s) armed <= 1'b0;
                            end
                        end
                        default: state <= RX_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/uart_transceiver_param.sv
// Parametrised full-duplex UART with ready/valid transmit side.
// Optional feature macro: UART_LOOPBACK_EN (internal tx->rx loopback).
module uart_transceiver_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int BAUD_DIV  = 27
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int BIT_CLKS = OVERSAMPLE * BAUD_DIV;
    localparam int CW       = $clog2(BIT_CLKS);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || BAUD_DIV < 1) begin : g_bad_param
        $error("uart_transceiver_param: illegal parameter value");
    end

    tx_state_t            tx_state;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_q;
    logic                 tx_rdy_q;
    logic [CW-1:0]        tx_cnt;
    logic [3:0]           tx_idx;
    logic                 tx_stop_idx;
    logic                 bit_end;
    logic                 rx_in;
    logic                 rx_idle;

    assign bit_end  = (tx_cnt == CW'(BIT_CLKS - 1));
    assign tx_ready = tx_rdy_q;

    // Transmit FSM: one bit period per state visit, LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state    <= TX_IDLE;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            tx_q        <= 1'b1;
            tx_rdy_q    <= 1'b1;
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_stop_idx <= 1'b0;
        end else begin
            if (tx_state != TX_IDLE) begin
                tx_cnt <= bit_end ? '0 : tx_cnt + CW'(1);
            end
            case (tx_state)
                TX_IDLE: begin
                    if (tx_valid) begin
                        tx_shift <= tx_data;
                        tx_par   <= parity_bit(9'(tx_data), DATA_BITS, PARITY);
                        tx_cnt   <= '0;
                        tx_q     <= 1'b0;
                        tx_rdy_q <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        tx_q     <= tx_shift[0];
                        tx_idx   <= '0;
                        tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        tx_idx <= tx_idx + 4'd1;
                        if (tx_idx == 4'(DATA_BITS - 1)) begin
                            tx_stop_idx <= 1'b0;
                            if (PARITY != PAR_NONE) begin
                                tx_q     <= tx_par;
                                tx_state <= TX_PARITY;
                            end else begin
                                tx_q     <= 1'b1;
                                tx_state <= TX_STOP;
                            end
                        end else begin
                            tx_shift <= tx_shift >> 1;
                            tx_q     <= tx_shift[1];
                        end
                    end
                end
                TX_PARITY: begin
                    if (bit_end) begin
                        tx_q        <= 1'b1;
                        tx_stop_idx <= 1'b0;
                        tx_state    <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        if (tx_stop_idx == 1'(STOP_BITS - 1)) begin
                            tx_rdy_q <= 1'b1;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_stop_idx <= 1'b1;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

`ifdef UART_LOOPBACK_EN
    logic lb_q;

    // Loopback mode only changes between frames on both directions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lb_q <= 1'b0;
        else if (tx_state == TX_IDLE && rx_idle) lb_q <= loopback;
    end

    assign tx    = lb_q ? 1'b1 : tx_q;
    assign rx_in = lb_q ? tx_q : rx;
`else
    logic unused_rx_idle;

    assign unused_rx_idle = rx_idle;
    assign tx    = tx_q;
    assign rx_in = rx;
`endif

    uart_rx_core #(
        .DATA_BITS (DATA_BITS),
        .PARITY    (PARITY),
        .BAUD_DIV  (BAUD_DIV)
    ) u_rx (
        .clk           (clk),
        .rst           (rst),
        .rx_in         (rx_in),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .idle          (rx_idle)
    );

endmodule
